coeff_update_scheduler: RTL and testbench
=========================================

Name: coeff_update_scheduler

Overview:
- Time-shares one coefficient_unit (CORDIC-based biquad coefficient generator) between NUM_CH filter channels.
- Arbitrates cutoff-update requests round-robin, clamps the cutoff, issues start, and waits for the unit's ready pulse with a timeout.
- Stages the five Q8.16 coefficients and commits them to the granted channel's coefficient bank only on a sample-boundary tick, so a filter never sees a half-updated set.
- Sits between the per-channel control registers and the biquad datapaths.

Parameters:
SAMPLE_WIDTH, 24, width of cutoff and of each coefficient (Q8.16)
NUM_CH, 4, number of filter channels sharing the coefficient unit
FC_MIN, 69, lowest legal cutoff code; lower requests are clamped up to this
FC_MAX, 1024, highest legal cutoff code; higher requests are clamped down to this
TIMEOUT, 64, maximum cycles spent in WAIT before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_CH  per-channel update request; level, held until ack
cutoff_in  in  NUM_CH*SAMPLE_WIDTH  packed cutoffs; channel i at [i*SAMPLE_WIDTH +: SAMPLE_WIDTH], unsigned
ack  out  NUM_CH  one-cycle pulse when that channel's bank is committed
cu_start  out  1  one-cycle start pulse to coefficient unit
cu_cutoff  out  SAMPLE_WIDTH  clamped cutoff to coefficient unit
cu_ready  in  1  one-cycle done pulse from coefficient unit
cu_b0, cu_b1, cu_b2, cu_a1, cu_a2  in  SAMPLE_WIDTH each  signed coefficients from coefficient unit
sample_tick  in  1  one-cycle sample-boundary strobe
b0_o, b1_o, b2_o, a1_o, a2_o  out  NUM_CH*SAMPLE_WIDTH each  per-channel coefficient banks, same packing as cutoff_in
busy  out  1  high whenever state is not IDLE
timeout_err  out  1  sticky; set on any WAIT timeout, cleared only by reset

Behaviour:
- Reset: state=IDLE; all banks=0; ack=0; cu_start=0; cu_cutoff=0; busy=0; timeout_err=0; staging=0; rr pointer=NUM_CH-1, so channel 0 has first priority.
- IDLE:
  - If any req is set, grant the first set bit searching from pointer+1 with wrap.
  - Register grant index; set pointer=grant.
  - cu_cutoff <= clamp(cutoff_in[grant], FC_MIN, FC_MAX); cu_start <= 1; go START.
  - req seen in cycle N gives cu_start=1 in cycle N+1.
- START (1 cycle): cu_start high this cycle only; reset wait counter to 0; go WAIT.
- WAIT: counter increments every cycle.
  - On cu_ready: capture cu_b0..cu_a2 into staging; go HOLD.
  - Else if counter reaches TIMEOUT-1: set timeout_err; no ack, no bank write; go IDLE.
  - After a timeout the pointer has already advanced, so other channels are not starved; the failed channel is retried when its turn recurs.
- HOLD: on sample_tick, copy staging into the granted channel's bank; pulse ack[grant] in the same cycle the bank updates; go IDLE.
- cu_cutoff stays stable from START until the next grant.
- cu_ready outside WAIT is ignored.
- sample_tick outside HOLD is ignored. sample_tick in the same cycle as cu_ready (in WAIT) does not commit; commit waits for the next tick.
- req dropping mid-transaction does not cancel it: commit and ack still occur.
- Requester must drop req the cycle after ack. A req still high in IDLE is treated as a new request, behind all other channels.
- Only the granted channel's bank changes; all other banks hold.
- Clamp is an unsigned compare on the full SAMPLE_WIDTH.
- Reset mid-operation: outputs return to reset values on the next edge; a late cu_ready after reset is ignored.

Test Plan:
- Single request: req[0]=1, cutoff 500 → cu_start pulse the next cycle with cu_cutoff=500. Model returns cu_ready after 18 cycles with b0=0x001234, a1=0xFE0000. sample_tick 5 cycles later → b0_o[ch0]=0x001234, a1_o[ch0]=0xFE0000, ack=4'b0001 in that cycle, banks 1-3 remain 0.
- Round-robin order: req=4'b1111 after reset → grants 0,1,2,3. Then req=4'b0101 → grants 0, then 2.
- Clamp: cutoff 10 → cu_cutoff=69; cutoff 5000 → cu_cutoff=1024; cutoff 1024 → 1024 unchanged.
- Timeout: model never asserts cu_ready → exactly 64 WAIT cycles, then timeout_err=1, no ack, next requesting channel granted. timeout_err stays 1 through later successful updates.
- Coincident events: cu_ready and sample_tick in the same cycle → no commit; next tick commits and pulses ack. A spurious cu_ready in IDLE causes no bank change.
- Reset in WAIT: reset asserted → next cycle busy=0, all banks 0, ack=0. A cu_ready 3 cycles later changes nothing.

Source files
------------

// File: rtl/coeff_update_scheduler_if.sv
// Handshake bundle between the coefficient update scheduler, the per-channel
// control registers, the shared coefficient unit and the biquad banks.
interface coeff_update_scheduler_if #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_CH       = 4
);
    logic [NUM_CH-1:0]              req;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] cutoff_in;
    logic [NUM_CH-1:0]              ack;
    logic                           cu_start;
    logic [SAMPLE_WIDTH-1:0]        cu_cutoff;
    logic                           cu_ready;
    logic [SAMPLE_WIDTH-1:0]        cu_b0, cu_b1, cu_b2, cu_a1, cu_a2;
    logic                           sample_tick;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] b0_o, b1_o, b2_o, a1_o, a2_o;
    logic                           busy;
    logic                           timeout_err;

    modport master (
        output req, cutoff_in, cu_ready, cu_b0, cu_b1, cu_b2, cu_a1, cu_a2, sample_tick,
        input  ack, cu_start, cu_cutoff, b0_o, b1_o, b2_o, a1_o, a2_o, busy, timeout_err
    );

    modport slave (
        input  req, cutoff_in, cu_ready, cu_b0, cu_b1, cu_b2, cu_a1, cu_a2, sample_tick,
        output ack, cu_start, cu_cutoff, b0_o, b1_o, b2_o, a1_o, a2_o, busy, timeout_err
    );
endinterface

// File: rtl/coeff_update_scheduler.sv
// Shares one coefficient unit among NUM_CH channels round-robin and commits each
// new coefficient set to its channel bank only on a sample-boundary tick.
module coeff_update_scheduler #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_CH       = 4,
    parameter int FC_MIN       = 69,
    parameter int FC_MAX       = 1024,
    parameter int TIMEOUT      = 64
) (
    input logic                     clk,
    input logic                     reset,
    coeff_update_scheduler_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    localparam logic [SAMPLE_WIDTH-1:0] FC_MIN_V = SAMPLE_WIDTH'(FC_MIN);
    localparam logic [SAMPLE_WIDTH-1:0] FC_MAX_V = SAMPLE_WIDTH'(FC_MAX);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

    state_t                         state;
    logic [CH_W-1:0]                ptr;
    logic [CH_W-1:0]                grant;
    logic [CH_W-1:0]                pick;
    logic [CH_W-1:0]                cand;
    logic                           pick_valid;
    logic [SAMPLE_WIDTH-1:0]        pick_cutoff;
    logic [SAMPLE_WIDTH-1:0]        clamped;
    logic [CNT_W-1:0]               wait_cnt;
    logic [SAMPLE_WIDTH-1:0]        stage_b0, stage_b1, stage_b2, stage_a1, stage_a2;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] bank_b0, bank_b1, bank_b2, bank_a1, bank_a2;
    logic [NUM_CH-1:0]              ack_q;
    logic                           cu_start_q;
    logic [SAMPLE_WIDTH-1:0]        cu_cutoff_q;
    logic                           timeout_q;

    // Round-robin search starts just after the last granted channel, so a
    // channel that keeps requesting falls behind every other requester.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!pick_valid && bus.req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
        pick_cutoff = bus.cutoff_in[int'(pick)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        if (pick_cutoff < FC_MIN_V)
            clamped = FC_MIN_V;
        else if (pick_cutoff > FC_MAX_V)
            clamped = FC_MAX_V;
        else
            clamped = pick_cutoff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= CH_W'(NUM_CH - 1);
            grant       <= '0;
            wait_cnt    <= '0;
            stage_b0    <= '0;
            stage_b1    <= '0;
            stage_b2    <= '0;
            stage_a1    <= '0;
            stage_a2    <= '0;
            bank_b0     <= '0;
            bank_b1     <= '0;
            bank_b2     <= '0;
            bank_a1     <= '0;
            bank_a2     <= '0;
            ack_q       <= '0;
            cu_start_q  <= 1'b0;
            cu_cutoff_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            ack_q      <= '0;
            cu_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant       <= pick;
                        ptr         <= pick;
                        cu_cutoff_q <= clamped;
                        cu_start_q  <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (bus.cu_ready) begin
                        stage_b0 <= bus.cu_b0;
                        stage_b1 <= bus.cu_b1;
                        stage_b2 <= bus.cu_b2;
                        stage_a1 <= bus.cu_a1;
                        stage_a2 <= bus.cu_a2;
                        state    <= HOLD;
                    end else if (wait_cnt == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HOLD: begin
                    // Banks only change on a sample boundary so a filter never mixes sets.
                    if (bus.sample_tick) begin
                        bank_b0[int'(grant)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_b0;
                        bank_b1[int'(grant)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_b1;
                        bank_b2[int'(grant)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_b2;
                        bank_a1[int'(grant)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_a1;
                        bank_a2[int'(grant)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= stage_a2;
                        ack_q[grant] <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack         = ack_q;
    assign bus.cu_start    = cu_start_q;
    assign bus.cu_cutoff   = cu_cutoff_q;
    assign bus.b0_o        = bank_b0;
    assign bus.b1_o        = bank_b1;
    assign bus.b2_o        = bank_b2;
    assign bus.a1_o        = bank_a1;
    assign bus.a2_o        = bank_a2;
    assign bus.busy        = (state != IDLE);
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_coeff_update_scheduler.sv
// Self-checking bench for coeff_update_scheduler: directed scenarios plus a
// randomized run against a round-robin / bank reference model.
`timescale 1ns/1ps
module tb_coeff_update_scheduler;
    localparam int SW = 24;
    localparam int NC = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   last;
    logic [SW-1:0] exp_bank [5][NC];

    coeff_update_scheduler_if #(.SAMPLE_WIDTH(SW), .NUM_CH(NC)) bus ();

    coeff_update_scheduler #(
        .SAMPLE_WIDTH(SW), .NUM_CH(NC), .FC_MIN(69), .FC_MAX(1024), .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [NC*SW-1:0] dut_bank(input int c);
        case (c)
            0:       return bus.b0_o;
            1:       return bus.b1_o;
            2:       return bus.b2_o;
            3:       return bus.a1_o;
            default: return bus.a2_o;
        endcase
    endfunction

    function automatic logic [NC*SW-1:0] exp_pack(input int c);
        logic [NC*SW-1:0] v;
        for (int ch = 0; ch < NC; ch++) v[ch*SW +: SW] = exp_bank[c][ch];
        return v;
    endfunction

    function automatic logic [SW-1:0] clamp_ref(input logic [SW-1:0] x);
        if (x < 24'd69)   return 24'd69;
        if (x > 24'd1024) return 24'd1024;
        return x;
    endfunction

    // Next channel in rotation order after 'from' that is requesting.
    function automatic int rr_ref(input logic [NC-1:0] r, input int from);
        for (int k = 1; k <= NC; k++) begin
            int c = (from + k) % NC;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_cut(input int ch, input logic [SW-1:0] v);
        bus.cutoff_in[ch*SW +: SW] = v;
    endtask

    task automatic clear_model();
        for (int c = 0; c < 5; c++)
            for (int ch = 0; ch < NC; ch++) exp_bank[c][ch] = '0;
        last = NC - 1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        bus.cutoff_in = '0;
        bus.cu_ready = 1'b0;
        bus.cu_b0 = '0; bus.cu_b1 = '0; bus.cu_b2 = '0; bus.cu_a1 = '0; bus.cu_a2 = '0;
        bus.sample_tick = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    // Plays the coefficient unit and the sample clock for one transaction.
    task automatic run_txn(input int ready_delay, input int tick_delay, input logic [SW-1:0] co [5],
                           input bit noise, output bit started, output logic [SW-1:0] cut_start,
                           output logic [SW-1:0] cut_end, output logic [NC-1:0] ack_seen);
        started = 1'b0; cut_end = '0; ack_seen = '0;
        tick();
        started = bus.cu_start;
        cut_start = bus.cu_cutoff;
        if (!started) return;
        for (int i = 0; i < ready_delay; i++) begin
            bus.sample_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus.cu_ready = 1'b1;
        bus.cu_b0 = co[0]; bus.cu_b1 = co[1]; bus.cu_b2 = co[2]; bus.cu_a1 = co[3]; bus.cu_a2 = co[4];
        bus.sample_tick = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        bus.cu_ready = 1'b0;
        bus.cu_b0 = 24'($urandom); bus.cu_b1 = 24'($urandom); bus.cu_b2 = 24'($urandom);
        bus.cu_a1 = 24'($urandom); bus.cu_a2 = 24'($urandom);
        bus.sample_tick = 1'b0;
        for (int j = 0; j < tick_delay; j++) tick();
        bus.sample_tick = 1'b1;
        tick();
        bus.sample_tick = 1'b0;
        ack_seen = bus.ack;
        cut_end = bus.cu_cutoff;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %0b required 0", bus.busy); end
        total++; if (bus.ack !== 4'b0) begin bad++; $display("[TB] FAIL reset_ack: got %0b required 0", bus.ack); end
        total++; if (bus.cu_start !== 1'b0) begin bad++; $display("[TB] FAIL reset_start: got %0b required 0", bus.cu_start); end
        total++; if (bus.cu_cutoff !== 24'd0) begin bad++; $display("[TB] FAIL reset_cutoff: got %0h required 0", bus.cu_cutoff); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout_err: got %0b required 0", bus.timeout_err); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== '0) begin bad++; $display("[TB] FAIL reset_bank%0d: got %0h required 0", c, dut_bank(c)); end
        end
    endtask

    task automatic test_single();
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        do_reset();
        co[0] = 24'h001234; co[1] = 24'h000500; co[2] = 24'h000600; co[3] = 24'hFE0000; co[4] = 24'h003000;
        set_cut(0, 24'd500);
        bus.req = 4'b0001;
        run_txn(18, 5, co, 1'b0, st, cs, ce, ak);
        bus.req = '0;
        for (int c = 0; c < 5; c++) exp_bank[c][0] = co[c];
        last = 0;
        total++; if (st !== 1'b1) begin bad++; $display("[TB] FAIL single_start: got %0b required 1", st); end
        total++; if (cs !== 24'd500) begin bad++; $display("[TB] FAIL single_cutoff: got %0d required 500", cs); end
        total++; if (ak !== 4'b0001) begin bad++; $display("[TB] FAIL single_ack: got %0b required 0001", ak); end
        total++; if (bus.b0_o[23:0] !== 24'h001234) begin bad++; $display("[TB] FAIL single_b0: got %0h required 001234", bus.b0_o[23:0]); end
        total++; if (bus.a1_o[23:0] !== 24'hFE0000) begin bad++; $display("[TB] FAIL single_a1: got %0h required fe0000", bus.a1_o[23:0]); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== exp_pack(c)) begin bad++; $display("[TB] FAIL single_bank%0d: got %0h required %0h", c, dut_bank(c), exp_pack(c)); end
        end
        tick();
        total++; if (bus.ack !== 4'b0) begin bad++; $display("[TB] FAIL single_ack_pulse: got %0b required 0", bus.ack); end
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 3, 0, 2};
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        do_reset();
        for (int ch = 0; ch < NC; ch++) set_cut(ch, 24'(100 * (ch + 1)));
        bus.req = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            if (n == 4) bus.req = 4'b0101;
            for (int c = 0; c < 5; c++) co[c] = 24'($urandom);
            run_txn(3 + n, n % 3, co, 1'b0, st, cs, ce, ak);
            bus.req[order[n]] = 1'b0;
            for (int c = 0; c < 5; c++) exp_bank[c][order[n]] = co[c];
            total++;
            if (cs !== 24'(100 * (order[n] + 1)))
                begin bad++; $display("[TB] FAIL rr_cutoff%0d: got %0d required %0d", n, cs, 100 * (order[n] + 1)); end
            total++;
            if (ak !== 4'(1 << order[n])) begin bad++; $display("[TB] FAIL rr_ack%0d: got %0b required %0b", n, ak, 4'(1 << order[n])); end
        end
        last = 2;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== exp_pack(c)) begin bad++; $display("[TB] FAIL rr_bank%0d: got %0h required %0h", c, dut_bank(c), exp_pack(c)); end
        end
    endtask

    task automatic test_clamp();
        logic [SW-1:0] ins  [8] = '{24'd10, 24'd5000, 24'd1024, 24'd69, 24'd68, 24'd1025, 24'hFFFFFF, 24'd0};
        logic [SW-1:0] outs [8] = '{24'd69, 24'd1024, 24'd1024, 24'd69, 24'd69, 24'd1024, 24'd1024, 24'd69};
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            for (int c = 0; c < 5; c++) co[c] = 24'($urandom);
            set_cut(n % NC, ins[n]);
            bus.req = 4'(1 << (n % NC));
            run_txn(2, 1, co, 1'b0, st, cs, ce, ak);
            bus.req = '0;
            total++; if (cs !== outs[n]) begin bad++; $display("[TB] FAIL clamp_start%0d: got %0d required %0d", n, cs, outs[n]); end
            total++; if (ce !== outs[n]) begin bad++; $display("[TB] FAIL clamp_hold%0d: got %0d required %0d", n, ce, outs[n]); end
        end
    endtask

    task automatic test_timeout();
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        do_reset();
        set_cut(0, 24'd300);
        set_cut(1, 24'd700);
        bus.req = 4'b0011;
        tick();
        total++; if (bus.cu_start !== 1'b1 || bus.cu_cutoff !== 24'd300)
            begin bad++; $display("[TB] FAIL to_start: got %0b/%0d required 1/300", bus.cu_start, bus.cu_cutoff); end
        tick();
        total++; if (bus.cu_start !== 1'b0) begin bad++; $display("[TB] FAIL to_start_pulse: got %0b required 0", bus.cu_start); end
        for (int i = 1; i < 64; i++) tick();
        total++; if (bus.busy !== 1'b1 || bus.timeout_err !== 1'b0)
            begin bad++; $display("[TB] FAIL to_wait64: got busy=%0b err=%0b required busy=1 err=0", bus.busy, bus.timeout_err); end
        tick();
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL to_err: got %0b required 1", bus.timeout_err); end
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0)
            begin bad++; $display("[TB] FAIL to_idle: got busy=%0b ack=%0b required 0/0", bus.busy, bus.ack); end
        for (int n = 0; n < 2; n++) begin
            int g = (n == 0) ? 1 : 0;
            for (int c = 0; c < 5; c++) co[c] = 24'($urandom);
            run_txn(5, 2, co, 1'b0, st, cs, ce, ak);
            bus.req[g] = 1'b0;
            for (int c = 0; c < 5; c++) exp_bank[c][g] = co[c];
            total++; if (cs !== 24'(g == 1 ? 700 : 300)) begin bad++; $display("[TB] FAIL to_next_cutoff%0d: got %0d required %0d", n, cs, g == 1 ? 700 : 300); end
            total++; if (ak !== 4'(1 << g)) begin bad++; $display("[TB] FAIL to_next_ack%0d: got %0b required %0b", n, ak, 4'(1 << g)); end
            total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky%0d: got %0b required 1", n, bus.timeout_err); end
        end
        last = 0;
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== exp_pack(c)) begin bad++; $display("[TB] FAIL to_bank%0d: got %0h required %0h", c, dut_bank(c), exp_pack(c)); end
        end
    endtask

    task automatic test_coincident();
        logic [SW-1:0] co [5];
        do_reset();
        bus.cu_ready = 1'b1;
        bus.cu_b0 = 24'hABCDEF; bus.cu_b1 = 24'h123456; bus.cu_b2 = 24'h654321; bus.cu_a1 = 24'h0F0F0F; bus.cu_a2 = 24'hF0F0F0;
        bus.sample_tick = 1'b1;
        tick();
        bus.cu_ready = 1'b0;
        bus.sample_tick = 1'b0;
        tick();
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0)
            begin bad++; $display("[TB] FAIL spur_idle: got busy=%0b ack=%0b required 0/0", bus.busy, bus.ack); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== '0) begin bad++; $display("[TB] FAIL spur_bank%0d: got %0h required 0", c, dut_bank(c)); end
        end
        for (int c = 0; c < 5; c++) co[c] = 24'($urandom);
        set_cut(2, 24'd2000);
        bus.req = 4'b0100;
        tick();
        total++; if (bus.cu_cutoff !== 24'd1024) begin bad++; $display("[TB] FAIL coin_cutoff: got %0d required 1024", bus.cu_cutoff); end
        for (int i = 0; i < 4; i++) tick();
        bus.cu_ready = 1'b1; bus.sample_tick = 1'b1;
        bus.cu_b0 = co[0]; bus.cu_b1 = co[1]; bus.cu_b2 = co[2]; bus.cu_a1 = co[3]; bus.cu_a2 = co[4];
        tick();
        bus.cu_ready = 1'b0; bus.sample_tick = 1'b0;
        total++; if (bus.ack !== 4'b0 || bus.busy !== 1'b1)
            begin bad++; $display("[TB] FAIL coin_nocommit: got ack=%0b busy=%0b required 0/1", bus.ack, bus.busy); end
        total++; if (bus.b0_o !== '0) begin bad++; $display("[TB] FAIL coin_bank_hold: got %0h required 0", bus.b0_o); end
        tick();
        tick();
        bus.req = 4'b0000;
        bus.sample_tick = 1'b1;
        tick();
        bus.sample_tick = 1'b0;
        for (int c = 0; c < 5; c++) exp_bank[c][2] = co[c];
        last = 2;
        total++; if (bus.ack !== 4'b0100) begin bad++; $display("[TB] FAIL coin_ack: got %0b required 0100", bus.ack); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== exp_pack(c)) begin bad++; $display("[TB] FAIL coin_bank%0d: got %0h required %0h", c, dut_bank(c), exp_pack(c)); end
        end
    endtask

    task automatic test_reset_in_wait();
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        do_reset();
        for (int c = 0; c < 5; c++) co[c] = 24'($urandom) | 24'h1;
        set_cut(3, 24'd900);
        bus.req = 4'b1000;
        run_txn(4, 0, co, 1'b0, st, cs, ce, ak);
        bus.req = '0;
        total++; if (ak !== 4'b1000) begin bad++; $display("[TB] FAIL rw_first_ack: got %0b required 1000", ak); end
        set_cut(1, 24'd800);
        bus.req = 4'b0010;
        tick();
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        bus.req = '0;
        tick();
        reset = 1'b0;
        clear_model();
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0 || bus.cu_start !== 1'b0 || bus.cu_cutoff !== 24'd0)
            begin bad++; $display("[TB] FAIL rw_outputs: got busy=%0b ack=%0b start=%0b cut=%0d required all 0",
                                  bus.busy, bus.ack, bus.cu_start, bus.cu_cutoff); end
        for (int c = 0; c < 5; c++) begin
            total++;
            if (dut_bank(c) !== '0) begin bad++; $display("[TB] FAIL rw_bank%0d: got %0h required 0", c, dut_bank(c)); end
        end
        tick();
        tick();
        bus.cu_ready = 1'b1;
        bus.cu_b0 = co[0]; bus.cu_b1 = co[1]; bus.cu_b2 = co[2]; bus.cu_a1 = co[3]; bus.cu_a2 = co[4];
        tick();
        bus.cu_ready = 1'b0;
        bus.sample_tick = 1'b1;
        tick();
        bus.sample_tick = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0)
            begin bad++; $display("[TB] FAIL rw_late_ready: got busy=%0b ack=%0b required 0/0", bus.busy, bus.ack); end
        total++; if (bus.a2_o !== '0) begin bad++; $display("[TB] FAIL rw_late_bank: got %0h required 0", bus.a2_o); end
    endtask

    task automatic test_random();
        logic [NC-1:0] pend;
        logic [SW-1:0] cuts [NC];
        logic [SW-1:0] co [5];
        bit st; logic [SW-1:0] cs, ce; logic [NC-1:0] ak;
        int g;
        do_reset();
        pend = '0;
        for (int n = 0; n < 30; n++) begin
            pend |= 4'($urandom_range(0, 15));
            if (pend == '0) pend[$urandom_range(0, NC - 1)] = 1'b1;
            for (int ch = 0; ch < NC; ch++) begin
                case ($urandom_range(0, 3))
                    0:       cuts[ch] = 24'($urandom_range(0, 68));
                    1:       cuts[ch] = 24'($urandom_range(69, 1024));
                    2:       cuts[ch] = 24'($urandom_range(1025, 5000));
                    default: cuts[ch] = 24'($urandom);
                endcase
                set_cut(ch, cuts[ch]);
            end
            for (int c = 0; c < 5; c++) co[c] = 24'($urandom);
            bus.req = pend;
            g = rr_ref(pend, last);
            run_txn($urandom_range(1, 40), $urandom_range(0, 8), co, 1'b1, st, cs, ce, ak);
            pend[g] = 1'b0;
            bus.req = pend;
            last = g;
            for (int c = 0; c < 5; c++) exp_bank[c][g] = co[c];
            total++;
            if (cs !== clamp_ref(cuts[g]) || ce !== clamp_ref(cuts[g]))
                begin bad++; $display("[TB] FAIL rand_cutoff%0d: got %0d/%0d required %0d", n, cs, ce, clamp_ref(cuts[g])); end
            total++;
            if (ak !== 4'(1 << g)) begin bad++; $display("[TB] FAIL rand_ack%0d: got %0b required %0b", n, ak, 4'(1 << g)); end
            for (int c = 0; c < 5; c++) begin
                total++;
                if (dut_bank(c) !== exp_pack(c))
                    begin bad++; $display("[TB] FAIL rand_bank%0d_%0d: got %0h required %0h", n, c, dut_bank(c), exp_pack(c)); end
            end
        end
        bus.req = '0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        clear_model();
        test_reset();
        test_single();
        test_round_robin();
        test_clamp();
        test_timeout();
        test_coincident();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
